// File: rtl/i2c_xfer_seq.sv
// rtl/i2c_xfer_seq.sv - I2C register-transaction sequencer driving an I2C master's register port
// Optional timeout on interrupt waits: define I2C_XFER_SEQ_TIMEOUT_EN.
module i2c_xfer_seq #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 3,
  parameter int A_PRE     = 0,
  parameter int A_CTR     = 1,
  parameter int A_TXRX    = 2,
  parameter int A_CMDSR   = 3,
  parameter int TO_CYCLES = 65535
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        prescale_i,
  input  logic              req_i,
  input  logic              rnw_i,
  input  logic [6:0]        dev_addr_i,
  input  logic [7:0]        reg_addr_i,
  input  logic [7:0]        wr_data_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [1:0]        err_code_o,
  output logic [7:0]        rd_data_o,
  output logic [AWIDTH-1:0] mst_addr_o,
  output logic [DWIDTH-1:0] mst_dout_o,
  output logic              mst_wr_o,
  input  logic [DWIDTH-1:0] mst_din_i,
  input  logic              mst_int_i
);

  typedef enum logic [4:0] {
    S_INIT, S_PRE, S_EN, S_IDLE, S_PUT, S_CMD, S_WAIT, S_STAT, S_STCAP, S_ACKI,
    S_STOP, S_SWAIT, S_SACK, S_RD, S_RDCAP, S_TO0, S_TO1, S_FIN
  } state_t;

  state_t state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wd_q, wd_d;
  logic [1:0] err_q, err_d;
  logic [7:0] rd_q, rd_d;
  logic       int_q, rxack_q, al_q;
  logic       to_hit;
  logic [7:0] byte_d, cmd_d;
  logic [AWIDTH-1:0] addr_d;
  logic [DWIDTH-1:0] dout_d;
  logic       wr_d, ready_d, done_d;
  logic       final_rd, last_wr;

  assign final_rd = rnw_q && (phase_q == 2'd3);
  assign last_wr  = !rnw_q && (phase_q == 2'd2);

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  // Cleared whenever outside a wait state, so it restarts at zero on every entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) to_cnt_q <= '0;
    else if (state_q == S_WAIT || state_q == S_SWAIT) to_cnt_q <= to_cnt_q + 16'd1;
    else to_cnt_q <= '0;
  end
  assign to_hit = (to_cnt_q == 16'(TO_CYCLES - 1));
`else
  logic unused_to_cycles;
  assign unused_to_cycles = (TO_CYCLES > 0);
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      S_INIT: state_d = S_PRE;
      S_PRE:  state_d = S_EN;
      S_EN:   state_d = S_IDLE;
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (req_i) begin
          rnw_d   = rnw_i;
          dev_d   = dev_addr_i;
          reg_d   = reg_addr_i;
          wd_d    = wr_data_i;
          err_d   = 2'b00;
          phase_d = 2'd0;
          state_d = S_PUT;
        end
      end
      S_PUT: state_d = S_CMD;
      S_CMD: state_d = S_WAIT;
      S_WAIT: begin
        if (int_q) state_d = S_STAT;
        else if (to_hit) begin
          err_d   = 2'b11;
          state_d = S_TO0;
        end
      end
      S_STAT:  state_d = S_STCAP;
      S_STCAP: state_d = S_ACKI;
      // Status check happens here, after the interrupt has already been acknowledged.
      S_ACKI: begin
        if (al_q) begin
          err_d   = 2'b10;
          state_d = S_FIN;
        end else if (rxack_q && !final_rd) begin
          err_d   = 2'b01;
          state_d = S_STOP;
        end else if (final_rd) state_d = S_RD;
        else if (last_wr) state_d = S_FIN;
        else begin
          phase_d = phase_q + 2'd1;
          state_d = (rnw_q && phase_q == 2'd2) ? S_CMD : S_PUT;
        end
      end
      S_STOP: state_d = S_SWAIT;
      S_SWAIT: begin
        if (int_q) state_d = S_SACK;
        else if (to_hit) begin
          err_d   = 2'b11;
          state_d = S_TO0;
        end
      end
      S_SACK:  state_d = S_FIN;
      S_RD:    state_d = S_RDCAP;
      S_RDCAP: begin
        rd_d    = mst_din_i;
        state_d = S_FIN;
      end
      S_TO0:   state_d = S_TO1;
      S_TO1:   state_d = S_FIN;
      default: state_d = S_INIT;
    endcase
  end

  // Bus outputs are registered, so they are decoded from the next state.
  always_comb begin
    case (phase_d)
      2'd0:    byte_d = {dev_d, 1'b0};
      2'd1:    byte_d = reg_d;
      2'd2:    byte_d = rnw_d ? {dev_d, 1'b1} : wd_d;
      default: byte_d = 8'h00;
    endcase
    case (phase_d)
      2'd0:    cmd_d = 8'h90;
      2'd1:    cmd_d = 8'h10;
      2'd2:    cmd_d = rnw_d ? 8'h90 : 8'h50;
      default: cmd_d = 8'h68;
    endcase
    addr_d  = '0;
    dout_d  = '0;
    wr_d    = 1'b0;
    ready_d = (state_d == S_IDLE) || (state_d == S_FIN);
    done_d  = (state_d == S_FIN);
    case (state_d)
      S_PRE:          begin wr_d = 1'b1; addr_d = AWIDTH'(A_PRE);   dout_d = prescale_i; end
      S_EN:           begin wr_d = 1'b1; addr_d = AWIDTH'(A_CTR);   dout_d = 8'h80; end
      S_PUT:          begin wr_d = 1'b1; addr_d = AWIDTH'(A_TXRX);  dout_d = byte_d; end
      S_CMD:          begin wr_d = 1'b1; addr_d = AWIDTH'(A_CMDSR); dout_d = cmd_d; end
      S_STAT, S_STCAP: addr_d = AWIDTH'(A_CMDSR);
      S_ACKI, S_SACK: begin wr_d = 1'b1; addr_d = AWIDTH'(A_CMDSR); dout_d = 8'h01; end
      S_STOP:         begin wr_d = 1'b1; addr_d = AWIDTH'(A_CMDSR); dout_d = 8'h40; end
      S_RD, S_RDCAP:  addr_d = AWIDTH'(A_TXRX);
      S_TO0:          begin wr_d = 1'b1; addr_d = AWIDTH'(A_CTR);   dout_d = 8'h00; end
      S_TO1:          begin wr_d = 1'b1; addr_d = AWIDTH'(A_CTR);   dout_d = 8'h80; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q    <= '0;
      rnw_q      <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wd_q       <= '0;
      err_q      <= '0;
      rd_q       <= '0;
      int_q      <= 1'b0;
      rxack_q    <= 1'b0;
      al_q       <= 1'b0;
      mst_addr_o <= '0;
      mst_dout_o <= '0;
      mst_wr_o   <= 1'b0;
      ready_o    <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      rnw_q      <= rnw_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      int_q      <= mst_int_i;
      if (state_q == S_STCAP) begin
        rxack_q <= mst_din_i[7];
        al_q    <= mst_din_i[5];
      end
      mst_addr_o <= addr_d;
      mst_dout_o <= dout_d;
      mst_wr_o   <= wr_d;
      ready_o    <= ready_d;
      done_o     <= done_d;
    end
  end

  assign err_code_o = err_q;
  assign rd_data_o  = rd_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// tb/tb_i2c_xfer_seq.sv - scoreboard bench for i2c_xfer_seq with a behavioural I2C master model
module tb_i2c_xfer_seq;

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
  localparam int TO_EXTRA = 2;
`else
  localparam int TO_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] prescale = 8'h00;
  logic       req = 1'b0;
  logic       rnw = 1'b0;
  logic [6:0] dev = 7'h00;
  logic [7:0] rga = 8'h00;
  logic [7:0] wd = 8'h00;
  logic       ready_o, done_o, mst_wr_o;
  logic [1:0] err_o;
  logic [7:0] rd_o, mst_dout_o;
  logic [2:0] mst_addr_o;
  logic [7:0] mst_din = 8'h00;
  logic       mst_int = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] exp_wr_q[$];
  logic [9:0]  exp_done_q[$];
  logic [7:0]  rd_model = 8'h00;
  logic [1:0]  last_err = 2'b00;

  logic [3:0] r_al = 4'h0, r_nack = 4'h0;
  logic [7:0] r_rx = 8'h00;
  int         r_hang = 99;
  int         r_phase = 0;
  int         int_cnt = 0;
  logic [7:0] pend = 8'h00, status_reg = 8'h00;

  i2c_xfer_seq #(.TO_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst), .prescale_i(prescale), .req_i(req), .rnw_i(rnw),
    .dev_addr_i(dev), .reg_addr_i(rga), .wr_data_i(wd),
    .ready_o(ready_o), .done_o(done_o), .err_code_o(err_o), .rd_data_o(rd_o),
    .mst_addr_o(mst_addr_o), .mst_dout_o(mst_dout_o), .mst_wr_o(mst_wr_o),
    .mst_din_i(mst_din), .mst_int_i(mst_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master model: registered DataOut (one cycle late), Int raised a few cycles after a command.
  always @(negedge clk) begin
    if (rst) begin
      mst_int = 1'b0; int_cnt = 0; pend = 8'h00; mst_din = 8'h00; r_phase = 0;
    end else begin
      if (ready_o) r_phase = 0;
      mst_din = pend;
      pend = (mst_addr_o == 3'd3) ? status_reg : (mst_addr_o == 3'd2) ? r_rx : 8'h00;
      if (int_cnt > 0) begin
        int_cnt--;
        if (int_cnt == 0) mst_int = 1'b1;
      end
      if (mst_wr_o && mst_addr_o == 3'd3) begin
        if (mst_dout_o == 8'h01) begin
          mst_int = 1'b0; int_cnt = 0;
        end else if (mst_dout_o == 8'h40) begin
          status_reg = 8'($urandom) & 8'h5F;
          int_cnt = $urandom_range(1, 4);
        end else begin
          status_reg = (8'($urandom) & 8'h5F) |
                       (r_phase < 4 ? {r_nack[r_phase[1:0]], 1'b0, r_al[r_phase[1:0]], 5'b0} : 8'h00);
          if (r_phase != r_hang) int_cnt = $urandom_range(1, 4);
          r_phase++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mst_wr_o) begin
        if (exp_wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got %0h expected none", {mst_addr_o, mst_dout_o});
        end else check("bus_write", {mst_addr_o, mst_dout_o}, exp_wr_q.pop_front());
      end
      if (done_o) begin
        check("ready_with_done", ready_o, 1'b1);
        if (exp_done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got %0h expected none", {err_o, rd_o});
        end else check("done_err_rd", {err_o, rd_o}, exp_done_q.pop_front());
      end
    end
  end

  // Reference: the transaction's bus writes and outcome derived from the phase rules.
  task automatic build_expected(input bit r, input logic [6:0] d, input logic [7:0] g,
                                input logic [7:0] w, input logic [7:0] rx,
                                input logic [3:0] al, input logic [3:0] nk, input int hang);
    logic [7:0] bytes[4];
    logic [7:0] cmds[4];
    int nph;
    bytes[0] = {d, 1'b0}; bytes[1] = g; bytes[2] = r ? {d, 1'b1} : w; bytes[3] = 8'h00;
    cmds[0] = 8'h90; cmds[1] = 8'h10; cmds[2] = r ? 8'h90 : 8'h50; cmds[3] = 8'h68;
    nph = r ? 4 : 3;
    for (int p = 0; p < nph; p++) begin
      if (!(r && p == 3)) exp_wr_q.push_back({3'd2, bytes[p]});
      exp_wr_q.push_back({3'd3, cmds[p]});
      if (p == hang) begin
`ifdef I2C_XFER_SEQ_TIMEOUT_EN
        exp_wr_q.push_back({3'd1, 8'h00});
        exp_wr_q.push_back({3'd1, 8'h80});
        last_err = 2'b11;
        exp_done_q.push_back({2'b11, rd_model});
`endif
        return;
      end
      exp_wr_q.push_back({3'd3, 8'h01});
      if (al[p]) begin
        last_err = 2'b10;
        exp_done_q.push_back({2'b10, rd_model});
        return;
      end
      if (nk[p] && !(r && p == 3)) begin
        exp_wr_q.push_back({3'd3, 8'h40});
        exp_wr_q.push_back({3'd3, 8'h01});
        last_err = 2'b01;
        exp_done_q.push_back({2'b01, rd_model});
        return;
      end
    end
    if (r) rd_model = rx;
    last_err = 2'b00;
    exp_done_q.push_back({2'b00, rd_model});
  endtask

  task automatic run_xfer(input bit r, input logic [6:0] d, input logic [7:0] g,
                          input logic [7:0] w, input logic [7:0] rx,
                          input logic [3:0] al, input logic [3:0] nk,
                          input int hang, input bit poke);
    int i;
    i = 0;
    @(negedge clk);
    while (!ready_o && i < 500) begin @(negedge clk); i++; end
    check("ready_before_req", ready_o, 1'b1);
    check("err_held", err_o, last_err);
    check("rd_held", rd_o, rd_model);
    r_al = al; r_nack = nk; r_rx = rx; r_hang = hang;
    build_expected(r, d, g, w, rx, al, nk, hang);
    rnw = r; dev = d; rga = g; wd = w; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("first_put_latency", {mst_wr_o, mst_addr_o}, {1'b1, 3'd2});
    if (poke) begin
      repeat (3) @(negedge clk);
      rnw = ~r; dev = 7'($urandom); rga = 8'($urandom); wd = 8'($urandom); req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    if (hang < 0) begin
      i = 0;
      while (exp_done_q.size() > 0 && i < 3000) begin @(negedge clk); i++; end
      check("done_within_bound", exp_done_q.size(), 0);
      check("writes_drained", exp_wr_q.size(), 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ready", ready_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 2'b00);
    check("rst_rd", rd_o, 8'h00);
    check("rst_bus", {mst_wr_o, mst_addr_o, mst_dout_o}, 12'h000);
    exp_wr_q.delete();
    exp_done_q.delete();
    rd_model = 8'h00; last_err = 2'b00; r_hang = 99;
    repeat (2) @(negedge clk);
    prescale = 8'($urandom);
    exp_wr_q.push_back({3'd0, prescale});
    exp_wr_q.push_back({3'd1, 8'h80});
    rst = 1'b0;
    @(negedge clk); check("init_c1_ready", ready_o, 1'b0);
    @(negedge clk); check("init_c2_ready", ready_o, 1'b0);
    @(negedge clk); check("init_c3_ready", ready_o, 1'b1);
    check("init_writes", exp_wr_q.size(), 0);
  endtask

  initial begin
    int i, ph, kind;
    logic [3:0] al, nk;
    do_reset();
    run_xfer(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 4'h0, 4'h0, -1, 1'b0);
    run_xfer(1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, 4'h0, 4'h0, -1, 1'b0);
    run_xfer(1'b1, 7'h50, 8'h10, 8'h00, 8'h77, 4'h0, 4'h1, -1, 1'b0);
    run_xfer(1'b0, 7'h2A, 8'h03, 8'h5A, 8'h00, 4'h2, 4'h0, -1, 1'b1);
    run_xfer(1'b1, 7'h11, 8'h22, 8'h00, 8'hC3, 4'h0, 4'h8, -1, 1'b1);

    run_xfer(1'b1, 7'h33, 8'h44, 8'h00, 8'h99, 4'h0, 4'h0, 0, 1'b0);
    repeat (300) @(negedge clk);
    check("hang_done_count", exp_done_q.size(), 0);
    check("hang_writes", exp_wr_q.size(), 0);
    do_reset();

    run_xfer(1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, 4'h0, 4'h0, 1, 1'b0);
    i = 0;
    while (r_phase < 2 && i < 500) begin @(negedge clk); i++; end
    check("reached_phase2_wait", r_phase >= 2, 1'b1);
    repeat (5) @(negedge clk);
    check("mid_reset_pending", exp_wr_q.size(), TO_EXTRA);
    do_reset();

    for (int t = 0; t < 40; t++) begin
      al = 4'h0; nk = 4'h0;
      kind = $urandom_range(0, 3);
      ph = $urandom_range(0, 3);
      if (kind == 2) al[ph] = 1'b1;
      if (kind == 3) nk[ph] = 1'b1;
      run_xfer(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               al, nk, -1, 1'($urandom));
    end
    repeat (5) @(negedge clk);
    check("final_wr_queue", exp_wr_q.size(), 0);
    check("final_done_queue", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
